// File: rtl/fifo_burst_reader_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream of fifo_burst_reader.
//   fifo_empty  FIFO empty flag            (FIFO -> reader)
//   fifo_r_en   FIFO pop strobe            (reader -> FIFO)
//   fifo_data   FIFO read data, registered (FIFO -> reader)
//   m_valid     output word valid          (reader -> consumer)
//   m_data      output word                (reader -> consumer)
//   m_ready     downstream accept          (consumer -> reader)
// master = reader side, slave = FIFO/consumer side.
interface fifo_burst_reader_if #(
  parameter int unsigned DW = 8
) ();
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_r_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for a synchronous FIFO. On start it pops exactly len words and forwards
// them through a 3-entry output buffer onto a valid/ready stream; done pulses once the burst's
// last word has been handed off.
//   clk, rst    clock and synchronous active-high reset
//   start, len  1-cycle burst request and word count (sampled in idle only)
//   busy, done  burst in progress / end-of-burst pulse
//   pop_count   handshakes completed in the current burst
//   bus         FIFO read port and output stream (master modport)
module fifo_burst_reader #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    pop_count,
  fifo_burst_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] pop_count_q, pop_count_d;
  logic [1:0]       occ_q, occ_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic             inflight_q, inflight_d;
  logic [DW-1:0]    mem_q [3];
  logic [DW-1:0]    mem_d [3];

  logic       r_en;
  logic       pop;
  logic       start_ok;
  logic [2:0] credit_used;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // State register (FSM plus datapath).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      pop_count_q <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;  // a read in flight at reset is dropped
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pop_count_q <= pop_count_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      for (int i = 0; i < 3; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Issue only from registered occupancy so m_ready never reaches fifo_r_en combinationally;
  // every outstanding read (buffered or in flight) holds one of the 3 buffer slots.
  always_comb begin
    credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
    r_en        = (state_q == StRun) && !bus.fifo_empty && (remaining_q != '0) &&
                  (credit_used < 3'd3);
    pop         = (occ_q != 2'd0) && bus.m_ready;
    start_ok    = (state_q == StIdle) && start;
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pop_count_d = pop_count_q;
    occ_d       = occ_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = r_en;
    for (int i = 0; i < 3; i++) mem_d[i] = mem_q[i];

    unique case (state_q)
      StIdle:  if (start) state_d = (len != '0) ? StRun : StDone;
      StRun:   if (r_en && (remaining_q == LEN_W'(1))) state_d = StDrain;
      StDrain: if ((occ_q == 2'd0) && !inflight_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (start_ok) begin
      remaining_d = len;
      pop_count_d = '0;
    end else begin
      if (r_en) remaining_d = remaining_q - LEN_W'(1);
      if (pop)  pop_count_d = pop_count_q + LEN_W'(1);
    end

    // Registered FIFO read: data lands the cycle after the pop strobe.
    if (inflight_q) begin
      mem_d[wr_ptr_q] = bus.fifo_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Outputs.
  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    pop_count     = pop_count_q;
    bus.fifo_r_en = r_en;
    bus.m_valid   = (occ_q != 2'd0);
    bus.m_data    = mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural FIFO model on the read port,
// scoreboard of expected words, stall/credit monitor, directed burst scenarios.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic       busy, done;
  logic [7:0] pop_count;

  fifo_burst_reader_if #(.DW(8)) bus ();

  fifo_burst_reader #(.DW(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .pop_count (pop_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // FIFO model with registered read data.
  logic [7:0] fifo_q [$];
  logic [7:0] pend [$];
  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.m_ready    = 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      pend.delete();
    end else begin
      if (bus.fifo_r_en) begin
        if (bus.fifo_empty) check("rd_empty", 32'd1, 32'd0);
        if (fifo_q.size() != 0) bus.fifo_data <= fifo_q.pop_front();
      end
      while (pend.size() != 0) fifo_q.push_back(pend.pop_front());
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Scoreboard and stream monitor, sampled on the falling edge.
  logic [7:0] exp_q [$];
  int rd_cnt = 0, hs_cnt = 0, done_cnt = 0, cyc_n = 0;
  int first_hs = -1, last_hs = -1;
  logic       stall_prev = 1'b0;
  logic [7:0] held = '0;

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      stall_prev = 1'b0;
      rd_cnt     = hs_cnt;
    end else begin
      if (stall_prev) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_data", bus.m_data, held);
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held       = bus.m_data;
      if (bus.fifo_r_en) check("credit", (rd_cnt - hs_cnt) < 3, 1);
      if (bus.fifo_r_en) rd_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", bus.m_data, 32'hdead);
        else check("data", bus.m_data, exp_q.pop_front());
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc_n;
        last_hs = cyc_n;
      end
      if (done) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      pend.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
  endtask

  task automatic burst(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      cyc(1);
      k++;
    end
    check("done_timeout", k < budget, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_r_en"}, bus.fifo_r_en, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_data"}, bus.m_data, 0);
    check({tag, "_pop_count"}, pop_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int dn, rd0, hs0, k;

    // Reset state.
    cyc(2);
    check_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Reset mid-burst: stop after the third word, nothing may appear afterwards.
    load(8'h10, 10);
    cyc(2);
    hs0 = hs_cnt;
    burst(10);
    k = 0;
    while (hs_cnt - hs0 < 3 && k < 50) begin
      cyc(1);
      k++;
    end
    check("rst_mid_reach", k < 50, 1);
    rst = 1'b1;
    cyc(1);
    check_zero("rst_mid");
    exp_q.delete();
    rst = 1'b0;
    cyc(5);
    check("rst_no_late_valid", bus.m_valid, 0);
    check("rst_idle", busy, 0);

    // Streaming at full throughput.
    load(8'hA0, 10);
    cyc(2);
    dn = done_cnt;
    first_hs = -1;
    burst(10);
    check("stream_busy", busy, 1);
    wait_done(60);
    check("stream_pop_count", pop_count, 10);
    check("stream_back_to_back", last_hs - first_hs, 9);
    cyc(2);
    check("stream_done_once", done_cnt - dn, 1);
    check("stream_sb_empty", exp_q.size(), 0);
    check("stream_pop_count_held", pop_count, 10);
    check("stream_idle", busy, 0);

    // Backpressure: buffer must fill to 3 and stop issuing.
    load(8'h30, 6);
    cyc(2);
    burst(6);
    cyc(1);
    bus.m_ready = 1'b0;
    cyc(5);
    check("bp_outstanding", rd_cnt - hs_cnt, 3);
    check("bp_r_en_off", bus.fifo_r_en, 0);
    bus.m_ready = 1'b1;
    wait_done(60);
    check("bp_pop_count", pop_count, 6);
    cyc(1);
    check("bp_sb_empty", exp_q.size(), 0);

    // Underrun: only 4 of 8 words present, refill later.
    dn  = done_cnt;
    rd0 = rd_cnt;
    load(8'h50, 4);
    cyc(2);
    burst(8);
    cyc(10);
    check("ur_paused_reads", rd_cnt - rd0, 4);
    check("ur_still_busy", busy, 1);
    load(8'h54, 4);
    wait_done(60);
    check("ur_pop_count", pop_count, 8);
    cyc(2);
    check("ur_done_once", done_cnt - dn, 1);
    check("ur_sb_empty", exp_q.size(), 0);

    // len=0: straight to done with no pops.
    rd0 = rd_cnt;
    burst(0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    cyc(1);
    check("len0_done_clear", done, 0);
    check("len0_idle", busy, 0);
    check("len0_no_reads", rd_cnt - rd0, 0);

    // start while busy is ignored.
    dn  = done_cnt;
    rd0 = rd_cnt;
    load(8'h70, 4);
    cyc(2);
    bus.m_ready = 1'b0;
    burst(4);
    cyc(1);
    burst(9);
    bus.m_ready = 1'b1;
    wait_done(60);
    check("busy_start_pop_count", pop_count, 4);
    cyc(2);
    check("busy_start_reads", rd_cnt - rd0, 4);
    check("busy_start_done_once", done_cnt - dn, 1);
    check("busy_start_sb_empty", exp_q.size(), 0);
    check("busy_start_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
